// File: rtl/mesi_cache_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : mesi_cache_ctrl
// Brief    : Direct-mapped MESI cache controller for one CPU core on a shared
//            snooping bus. Handles CPU request/ready handshake, bus arbitration,
//            line fill, dirty-victim write-back and snoop responses with flush.
// Options  : MESI_BUSUPGR_EN - a write hit on a Shared line issues BusUpgr
//            (no data transfer) instead of BusRdX followed by a fill.
// Revision : 1.0 - initial release
//==============================================================================

package mesi_types;
   typedef enum logic [1:0] {
      No_OP   = 2'd0,
      BusRd   = 2'd1,
      BusRdX  = 2'd2,
      BusUpgr = 2'd3
   } bus_request;

   typedef enum logic [1:0] {
      Invalid   = 2'd0,
      Shared    = 2'd1,
      Exclusive = 2'd2,
      Modified  = 2'd3
   } cache_state;
endpackage

module mesi_cache_ctrl
   import mesi_types::*;
#(
   parameter int LINES  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              bus_req,
   input  logic              bus_gnt,
   output bus_request        bus_cmd_out,
   output logic [ADDR_W-1:0] bus_addr_out,
   input  logic [DATA_W-1:0] bus_data_in,
   input  logic              bus_data_valid,
   input  logic              bus_shared_in,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   input  logic              wb_ack,
   input  logic              snoop_valid,
   input  bus_request        snoop_cmd,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              snoop_shared,
   output logic              snoop_flush,
   output logic [DATA_W-1:0] snoop_data
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_EVICT = 3'd1,
      ST_ARB   = 3'd2,
      ST_FILL  = 3'd3,
      ST_DONE  = 3'd4
   } fsm_t;

   fsm_t              fsm_q, fsm_d;
   cache_state        state_q [LINES];
   logic [TAG_W-1:0]  tag_q   [LINES];
   logic [DATA_W-1:0] data_q  [LINES];

   // Request latched when it leaves IDLE; the CPU holds it anyway, but the
   // latched copy keeps the transaction self-consistent.
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   bus_request        cmd_q, cmd_d;
   logic [DATA_W-1:0] rdata_q;
   logic              snp_shared_q, snp_flush_q;
   logic [DATA_W-1:0] snp_data_q;

   logic [IDX_W-1:0]  cpu_idx, req_idx, snp_idx;
   logic [TAG_W-1:0]  cpu_tag, req_tag, snp_tag;
   logic              cpu_req, cpu_hit, snp_hit, snp_same, snp_evict, upgr_lost;
   cache_state        snp_state, fill_state;
   logic              snp_do_flush;
   logic [DATA_W-1:0] fill_data;
   bus_request        eff_cmd;
   logic              do_capture, do_hit_rd, do_hit_wr, do_evict_ack, do_upgr, do_fill;

   assign cpu_idx  = cpu_addr[IDX_W-1:0];
   assign cpu_tag  = cpu_addr[ADDR_W-1:IDX_W];
   assign req_idx  = addr_q[IDX_W-1:0];
   assign req_tag  = addr_q[ADDR_W-1:IDX_W];
   assign snp_idx  = snoop_addr[IDX_W-1:0];
   assign snp_tag  = snoop_addr[ADDR_W-1:IDX_W];

   assign cpu_req  = cpu_read | cpu_write;
   assign cpu_hit  = (state_q[cpu_idx] != Invalid) && (tag_q[cpu_idx] == cpu_tag);
   assign snp_hit  = snoop_valid && (state_q[snp_idx] != Invalid) && (tag_q[snp_idx] == snp_tag);
   // A snoop touching the line the CPU wants this cycle is serviced first.
   assign snp_same = snoop_valid && (snp_idx == cpu_idx);
   // A remote read/ownership request for the victim being written back
   // takes the data from our flush, so the write-back is abandoned.
   assign snp_evict = snp_hit && (fsm_q == ST_EVICT) && (snp_idx == req_idx) &&
                      ((snoop_cmd == BusRd) || (snoop_cmd == BusRdX));

   // An upgrade is only valid while we still hold the line Shared.
   assign upgr_lost = (state_q[req_idx] != Shared) || (tag_q[req_idx] != req_tag) ||
                      (snp_hit && (snp_idx == req_idx) && (snp_state == Invalid));
   assign eff_cmd   = ((cmd_q == BusUpgr) && upgr_lost) ? BusRdX : cmd_q;

   assign fill_state = (cmd_q == BusRdX) ? Modified : (bus_shared_in ? Shared : Exclusive);
   assign fill_data  = (cmd_q == BusRdX) ? wdata_q : bus_data_in;

   assign cpu_rdata    = rdata_q;
   assign snoop_shared = snp_shared_q;
   assign snoop_flush  = snp_flush_q;
   assign snoop_data   = snp_data_q;

   // Snoop response: next state of the snooped line and whether to flush it.
   always_comb begin
      snp_state    = state_q[snp_idx];
      snp_do_flush = 1'b0;
      case (snoop_cmd)
         BusRd: begin
            if (state_q[snp_idx] == Modified) begin
               snp_state    = Shared;
               snp_do_flush = 1'b1;
            end else if (state_q[snp_idx] == Exclusive) begin
               snp_state = Shared;
            end
         end
         BusRdX: begin
            snp_do_flush = (state_q[snp_idx] == Modified);
            snp_state    = Invalid;
         end
         BusUpgr: begin
            if (state_q[snp_idx] == Shared) begin
               snp_state = Invalid;
            end
         end
         default: ;
      endcase
      if (snp_evict) begin
         snp_state = Invalid;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm_q <= ST_IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // FSM next-state, bus/CPU/write-back outputs and datapath update strobes.
   always_comb begin
      fsm_d        = fsm_q;
      cmd_d        = cmd_q;
      cpu_ready    = 1'b0;
      bus_req      = 1'b0;
      bus_cmd_out  = No_OP;
      bus_addr_out = '0;
      wb_valid     = 1'b0;
      wb_addr      = '0;
      wb_data      = '0;
      do_capture   = 1'b0;
      do_hit_rd    = 1'b0;
      do_hit_wr    = 1'b0;
      do_evict_ack = 1'b0;
      do_upgr      = 1'b0;
      do_fill      = 1'b0;
      case (fsm_q)
         ST_IDLE: begin
            if (cpu_req && !snp_same) begin
               do_capture = 1'b1;
               if (cpu_hit && cpu_write && (state_q[cpu_idx] != Shared)) begin
                  do_hit_wr = 1'b1;
                  fsm_d     = ST_DONE;
               end else if (cpu_hit && cpu_write) begin
`ifdef MESI_BUSUPGR_EN
                  cmd_d = BusUpgr;
`else
                  cmd_d = BusRdX;
`endif
                  fsm_d = ST_ARB;
               end else if (cpu_hit) begin
                  do_hit_rd = 1'b1;
                  fsm_d     = ST_DONE;
               end else begin
                  cmd_d = cpu_write ? BusRdX : BusRd;
                  fsm_d = (state_q[cpu_idx] == Modified) ? ST_EVICT : ST_ARB;
               end
            end
         end
         ST_EVICT: begin
            wb_valid = 1'b1;
            wb_addr  = {tag_q[req_idx], req_idx};
            wb_data  = data_q[req_idx];
            if (snp_evict) begin
               fsm_d = ST_ARB;
            end else if (wb_ack) begin
               do_evict_ack = 1'b1;
               fsm_d        = ST_ARB;
            end
         end
         ST_ARB: begin
            bus_req = 1'b1;
            if (bus_gnt) begin
               bus_cmd_out  = eff_cmd;
               bus_addr_out = addr_q;
               cmd_d        = eff_cmd;
               if (eff_cmd == BusUpgr) begin
                  do_upgr = 1'b1;
                  fsm_d   = ST_DONE;
               end else begin
                  fsm_d = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            if (bus_data_valid) begin
               do_fill = 1'b1;
               fsm_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            cpu_ready = 1'b1;
            fsm_d     = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   // Line states, latched request and registered CPU/snoop outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < LINES; i++) begin
            state_q[i] <= Invalid;
         end
         addr_q       <= '0;
         wdata_q      <= '0;
         cmd_q        <= No_OP;
         rdata_q      <= '0;
         snp_shared_q <= 1'b0;
         snp_flush_q  <= 1'b0;
         snp_data_q   <= '0;
      end else begin
         cmd_q <= cmd_d;
         if (do_capture) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
         end
         if (do_hit_rd) begin
            rdata_q <= data_q[cpu_idx];
         end
         if (do_hit_wr) begin
            state_q[cpu_idx] <= Modified;
         end
         if (do_evict_ack || do_upgr) begin
            state_q[req_idx] <= do_upgr ? Modified : Invalid;
         end
         if (do_fill) begin
            state_q[req_idx] <= fill_state;
            rdata_q          <= fill_data;
         end
         // Snoop wins over local updates, except that a line being refilled
         // no longer belongs to the snooped (old) tag.
         if (snp_hit && !(do_fill && (snp_idx == req_idx))) begin
            state_q[snp_idx] <= snp_state;
         end
         snp_shared_q <= snp_hit;
         snp_flush_q  <= snp_hit && snp_do_flush;
         snp_data_q   <= (snp_hit && snp_do_flush) ? data_q[snp_idx] : '0;
      end
   end

   // Tag and data arrays: not reset, only written during normal operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (do_hit_wr) begin
            data_q[cpu_idx] <= cpu_wdata;
         end
         if (do_upgr) begin
            data_q[req_idx] <= wdata_q;
         end
         if (do_fill) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= fill_data;
         end
      end
   end

endmodule
`default_nettype wire
